ro_puf_pair_eval: RTL and testbench

Parametrised challenge-response evaluator for the ring-oscillator PUF. It takes NUM_RO free-running oscillator outputs (one per Ring_Oscillator instance), enables them, and counts rising edges of two challenge-selected oscillators over a fixed clock window. It then returns one response bit plus both counts over a valid/ready handshake. It sits between the oscillator bank and the key/response collection logic, replacing per-oscillator hand-probing with a single measured comparison per challenge.

---
 rtl/ro_puf_pair_eval.sv | 194 +++++++++++++++++++
 tb/tb_ro_puf_pair_eval.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_pair_eval.sv
// Ring-oscillator PUF pair evaluator: counts edges of two challenge-selected
// oscillators over a fixed clock window and returns the comparison bit.
module ro_puf_pair_eval #(
  parameter int NUM_RO     = 8,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 256,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              ro_enable,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic              resp_tie,
  output logic              resp_err,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_COUNT   = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PAD_W   = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_RO_L = NUM_RO[SEL_W:0];

  // Oscillator inputs are asynchronous: two-flop synchronizer plus edge-detect stage.
  logic [NUM_RO-1:0] sync1_q, sync2_q, dly_q;
  logic [NUM_RO-1:0] edge_pulse;
  logic [PAD_W-1:0]  pulse_pad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign edge_pulse = sync2_q & ~dly_q;

  always_comb begin
    pulse_pad               = '0;
    pulse_pad[NUM_RO-1:0]   = edge_pulse;
  end

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0] count_a_q, count_a_d, count_b_q, count_b_d;
  logic             resp_bit_q, resp_bit_d, resp_tie_q, resp_tie_d;
  logic             resp_err_q, resp_err_d, resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d, ro_enable_q, ro_enable_d;
  logic             sel_ok, pulse_a, pulse_b;

  assign pulse_a = pulse_pad[sel_a_q];
  assign pulse_b = pulse_pad[sel_b_q];

  // Response handshake: resp_valid stays high with all response fields frozen
  // until the edge where resp_valid & resp_ready; resp_valid is low the next cycle.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    resp_bit_d = resp_bit_q;
    resp_tie_d = resp_tie_q;
    resp_err_d = resp_err_q;
    sel_ok     = (sel_a != sel_b) && ({1'b0, sel_a} < NUM_RO_L) &&
                 ({1'b0, sel_b} < NUM_RO_L);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_a_d = sel_a;
          sel_b_d = sel_b;
          if (!sel_ok) begin
            resp_err_d = 1'b1;
            resp_bit_d = 1'b0;
            resp_tie_d = 1'b0;
            count_a_d  = '0;
            count_b_d  = '0;
            state_d    = ST_DONE;
          end else begin
            cnt_a_d = '0;
            cnt_b_d = '0;
            tmr_d   = TMR_W'(SETTLE_CYC - 1);
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(WINDOW - 1);
          state_d = ST_COUNT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COUNT: begin
        // Counters saturate rather than wrap so an overflow never flips the answer.
        if (pulse_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (pulse_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
        if (tmr_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COMPARE: begin
        resp_err_d = 1'b0;
        resp_bit_d = (cnt_a_q > cnt_b_q);
        resp_tie_d = (cnt_a_q == cnt_b_q);
        count_a_d  = cnt_a_q;
        count_b_d  = cnt_b_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    ro_enable_d  = (state_d == ST_SETTLE) || (state_d == ST_COUNT);
    resp_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      count_a_q    <= '0;
      count_b_q    <= '0;
      resp_bit_q   <= 1'b0;
      resp_tie_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ro_enable_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      count_a_q    <= count_a_d;
      count_b_q    <= count_b_d;
      resp_bit_q   <= resp_bit_d;
      resp_tie_q   <= resp_tie_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      ro_enable_q  <= ro_enable_d;
    end
  end

  assign ro_enable  = ro_enable_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign resp_tie   = resp_tie_q;
  assign resp_err   = resp_err_q;
  assign count_a    = count_a_q;
  assign count_b    = count_b_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ro_puf_pair_eval.sv
// Bench for ro_puf_pair_eval: two instances (8 oscillators/16-bit counts and
// 6 oscillators/4-bit counts), directed table, hand sequences and random runs.
module tb_ro_puf_pair_eval;
  localparam int S    = 4;
  localparam int W    = 64;
  localparam int MAXH = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // oscillator bank model
  int       per [8];
  int       ph  [8];
  logic [7:0] bank = '0;
  bit       rise_hist [8][MAXH];

  always @(negedge clk) begin : osc
    logic lvl;
    for (int n = 0; n < 8; n++) begin
      if (per[n] == 0) begin
        lvl = 1'b0;
      end else begin
        ph[n] = (ph[n] + 1) % per[n];
        lvl   = (ph[n] < per[n] / 2);
      end
      if (cyc + 1 < MAXH) rise_hist[n][cyc + 1] = lvl && !bank[n];
      bank[n] = lvl;
    end
  end

  // instance 0
  logic        start0 = 0, resp_ready0 = 0;
  logic [2:0]  sel_a0 = 0, sel_b0 = 0;
  logic        ro_enable0, busy0, resp_valid0, resp_bit0, resp_tie0, resp_err0;
  logic [15:0] count_a0, count_b0;
  logic [2:0]  dbg_state0;
  // instance 1
  logic        start1 = 0, resp_ready1 = 0;
  logic [2:0]  sel_a1 = 0, sel_b1 = 0;
  logic        ro_enable1, busy1, resp_valid1, resp_bit1, resp_tie1, resp_err1;
  logic [3:0]  count_a1, count_b1;
  logic [2:0]  dbg_state1;
  logic [5:0]  ro_in1;
  assign ro_in1 = bank[5:0];

  ro_puf_pair_eval #(.NUM_RO(8), .SEL_W(3), .CNT_W(16), .WINDOW(W), .SETTLE_CYC(S)) dut0 (
    .clk(clk), .rst(rst), .ro_in(bank), .ro_enable(ro_enable0), .start(start0),
    .sel_a(sel_a0), .sel_b(sel_b0), .busy(busy0), .resp_valid(resp_valid0),
    .resp_ready(resp_ready0), .resp_bit(resp_bit0), .resp_tie(resp_tie0),
    .resp_err(resp_err0), .count_a(count_a0), .count_b(count_b0), .dbg_state(dbg_state0));

  ro_puf_pair_eval #(.NUM_RO(6), .SEL_W(3), .CNT_W(4), .WINDOW(W), .SETTLE_CYC(S)) dut1 (
    .clk(clk), .rst(rst), .ro_in(ro_in1), .ro_enable(ro_enable1), .start(start1),
    .sel_a(sel_a1), .sel_b(sel_b1), .busy(busy1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready1), .resp_bit(resp_bit1), .resp_tie(resp_tie1),
    .resp_err(resp_err1), .count_a(count_a1), .count_b(count_b1), .dbg_state(dbg_state1));

  // view of the instance currently under test
  int          cur = 0;
  logic        v_valid, v_busy, v_en, v_bit, v_tie, v_err;
  logic [15:0] v_ca, v_cb;
  always_comb begin
    if (cur == 1) begin
      v_valid = resp_valid1; v_busy = busy1; v_en = ro_enable1;
      v_bit = resp_bit1; v_tie = resp_tie1; v_err = resp_err1;
      v_ca = {12'd0, count_a1}; v_cb = {12'd0, count_b1};
    end else begin
      v_valid = resp_valid0; v_busy = busy0; v_en = ro_enable0;
      v_bit = resp_bit0; v_tie = resp_tie0; v_err = resp_err0;
      v_ca = count_a0; v_cb = count_b0;
    end
  end

  int    n_tests = 0;
  int    n_fail  = 0;
  string ctx     = "reset";

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", ctx, name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
    n_tests++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d +/- %0d", ctx, name, act, exp, tol);
    end
  endtask

  task automatic set_start(input int inst, input bit s, input int sa, input int sb);
    if (inst == 1) begin start1 = s; sel_a1 = sa[2:0]; sel_b1 = sb[2:0]; end
    else begin start0 = s; sel_a0 = sa[2:0]; sel_b0 = sb[2:0]; end
  endtask

  task automatic set_ready(input int inst, input bit r);
    if (inst == 1) resp_ready1 = r; else resp_ready0 = r;
  endtask

  task automatic set_bank(input int a, input int pa, input int b, input int pb);
    for (int n = 0; n < 8; n++) begin per[n] = 0; ph[n] = 0; end
    if (a < 8) per[a] = pa;
    if (b < 8) per[b] = pb;
  endtask

  function automatic int edges_in(input int n, input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) if (k >= 0 && k < MAXH) s += rise_hist[n][k];
    return s;
  endfunction

  // One full challenge: start, wait for response, check against the model,
  // optionally hold off resp_ready (and poke start meanwhile), then consume.
  task automatic measure(input int inst, input int sa, input int sb, input int ready_dly,
                         input bit pre_ready, output bit o_err, output bit o_bit,
                         output bit o_tie, output int o_ca, output int o_cb, output int o_lat);
    int k0, n_en, n_busy, nro, cmax, ea, eb, exp_lat;
    bit got, ok;
    cur = inst;
    set_ready(inst, pre_ready);
    set_start(inst, 1'b1, sa, sb);
    k0 = cyc + 1;
    @(negedge clk);
    set_start(inst, 1'b0, 0, 0);
    n_en = 0; n_busy = 0; got = 0; o_lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (v_en) n_en++;
      if (v_busy) n_busy++;
      if (v_valid) begin got = 1; o_lat = cyc - k0 + 1; end
    end
    chk("valid_seen", got, 1);
    o_err = v_err; o_bit = v_bit; o_tie = v_tie; o_ca = v_ca; o_cb = v_cb;
    nro  = (inst == 1) ? 6 : 8;
    cmax = (inst == 1) ? 15 : 65535;
    ok   = (sa != sb) && (sa < nro) && (sb < nro);
    if (ok) begin
      ea = edges_in(sa, k0 + S - 1, k0 + S + W - 2);
      eb = edges_in(sb, k0 + S - 1, k0 + S + W - 2);
      if (ea > cmax) ea = cmax;
      if (eb > cmax) eb = cmax;
      exp_lat = S + W + 2;
    end else begin
      ea = 0; eb = 0; exp_lat = 1;
    end
    if (got) begin
      chk("latency", o_lat, exp_lat);
      chk("resp_err", o_err, !ok);
      chk("resp_bit", o_bit, ea > eb);
      chk("resp_tie", o_tie, ok && (ea == eb));
      chk("count_a", o_ca, ea);
      chk("count_b", o_cb, eb);
      chk("enable_cycles", n_en, ok ? S + W : 0);
      chk("busy_cycles", n_busy, exp_lat);
      if (!pre_ready) begin
        for (int i = 0; i < ready_dly; i++) begin
          if (i == 4) set_start(inst, 1'b1, 1, 0);
          @(negedge clk);
          if (i == 4) set_start(inst, 1'b0, 0, 0);
          chk("hold_valid", v_valid, 1);
          chk("hold_busy", v_busy, 1);
          chk("hold_count_a", v_ca, ea);
          chk("hold_count_b", v_cb, eb);
          chk("hold_bit", v_bit, ea > eb);
        end
        set_ready(inst, 1'b1);
      end
      @(negedge clk);
      chk("post_valid", v_valid, 0);
      chk("post_busy", v_busy, 0);
    end
    set_ready(inst, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_busy", v_busy, 0);
    chk("idle_enable", v_en, 0);
  endtask

  typedef struct {
    int inst; int sa; int sb; int pa; int pb;
    bit err; bit rbit; bit tie; int lat; int ca; int cb;
  } vec_t;

  vec_t tbl [7];

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    bit   e, b, t;
    int   ca, cb, lat;
    tbl[0] = '{0, 2, 5, 4, 8,  1'b0, 1'b1, 1'b0, 70, 16, 8};
    tbl[1] = '{0, 5, 2, 8, 4,  1'b0, 1'b0, 1'b0, 70, 8, 16};
    tbl[2] = '{0, 2, 2, 4, 4,  1'b1, 1'b0, 1'b0, 1,  0, 0};
    tbl[3] = '{1, 0, 1, 4, 4,  1'b0, 1'b0, 1'b1, 70, 15, 15};
    tbl[4] = '{1, 3, 6, 4, 4,  1'b1, 1'b0, 1'b0, 1,  0, 0};
    tbl[5] = '{0, 7, 0, 6, 10, 1'b0, 1'b1, 1'b0, 70, 11, 6};
    tbl[6] = '{0, 0, 1, 4, 4,  1'b0, 1'b0, 1'b1, 70, 16, 16};
    for (int n = 0; n < 8; n++) begin per[n] = 0; ph[n] = 0; end

    // reset values of both instances
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur = i;
      #1;
      chk("rst_enable", v_en, 0);
      chk("rst_busy", v_busy, 0);
      chk("rst_valid", v_valid, 0);
      chk("rst_bit", v_bit, 0);
      chk("rst_tie", v_tie, 0);
      chk("rst_err", v_err, 0);
      chk("rst_count_a", v_ca, 0);
      chk("rst_count_b", v_cb, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // directed table
    for (int v = 0; v < 7; v++) begin
      ctx = $sformatf("tbl%0d", v);
      set_bank(tbl[v].sa, tbl[v].pa, tbl[v].sb, tbl[v].pb);
      repeat (8) @(negedge clk);
      measure(tbl[v].inst, tbl[v].sa, tbl[v].sb, 1, 1'b0, e, b, t, ca, cb, lat);
      chk("nom_err", e, tbl[v].err);
      chk("nom_bit", b, tbl[v].rbit);
      chk("nom_tie", t, tbl[v].tie);
      chk("nom_lat", lat, tbl[v].lat);
      chk_tol("nom_count_a", ca, tbl[v].ca, 1);
      chk_tol("nom_count_b", cb, tbl[v].cb, 1);
    end

    // response held off for 10 cycles with a start pulse in between
    ctx = "backpressure";
    set_bank(2, 4, 5, 8);
    repeat (8) @(negedge clk);
    measure(0, 2, 5, 10, 1'b0, e, b, t, ca, cb, lat);

    // ready asserted before valid must not change timing
    ctx = "early_ready";
    measure(0, 2, 5, 0, 1'b1, e, b, t, ca, cb, lat);
    chk("nom_lat", lat, 70);

    // asynchronous reset in the middle of COUNT
    ctx = "rst_mid";
    cur = 0;
    set_start(0, 1'b1, 2, 5);
    @(negedge clk);
    set_start(0, 1'b0, 0, 0);
    repeat (29) @(negedge clk);
    chk("enable_before", ro_enable0, 1);
    rst = 1'b1;
    #1;
    chk("enable", ro_enable0, 0);
    chk("busy", busy0, 0);
    chk("valid", resp_valid0, 0);
    chk("count_a", count_a0, 0);
    chk("count_b", count_b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_resume", busy0, 0);
    measure(0, 2, 5, 2, 1'b0, e, b, t, ca, cb, lat);
    chk("nom_lat", lat, 70);
    chk_tol("nom_count_a", ca, 16, 1);
    chk_tol("nom_count_b", cb, 8, 1);
    chk("nom_bit", b, 1);

    // randomized challenges against the reference model
    for (int r = 0; r < 24; r++) begin
      int inst, sa, sb;
      ctx = $sformatf("rand%0d", r);
      for (int n = 0; n < 8; n++) begin
        int k;
        k = $urandom_range(0, 7);
        per[n] = (k == 0) ? 0 : 2 * (k + 1);
        ph[n]  = (per[n] == 0) ? 0 : $urandom_range(0, per[n] - 1);
      end
      inst = $urandom_range(0, 1);
      sa   = $urandom_range(0, 7);
      sb   = ($urandom_range(0, 7) == 0) ? sa : $urandom_range(0, 7);
      repeat ($urandom_range(2, 6)) @(negedge clk);
      measure(inst, sa, sb, $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
              e, b, t, ca, cb, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
